// File: rtl/fifo_gen_relay.sv
// fifo_gen_relay: FWFT relay FIFO with PIPE_LEVEL flop stages on the data path and on the credit path.
// The sink-side buffer holds DEPTH entries so that it can absorb every write already in flight.
module fifo_gen_relay #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int PIPE_LEVEL = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_data_vld,
    input  logic [DATA_WIDTH-1:0]        s_data,
    output logic                         s_read,
    output logic                         m_data_vld,
    output logic [DATA_WIDTH-1:0]        m_data,
    input  logic                         m_read,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH  = $clog2(DEPTH+1);

    logic                  wr_en, full, pop, wr_acc;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_comb begin
        full       = count_q == CNT_WIDTH'(DEPTH);
        pop        = m_read && count_q != '0;
        wr_acc     = wr_en && (!full || pop);
        wr_ptr_d   = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CNT_WIDTH'(wr_acc) - CNT_WIDTH'(pop);
        overflow_d = overflow_q || (wr_en && full && !pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is left unreset; m_data is only meaningful while m_data_vld is high.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= wr_data;
    end

    assign m_data_vld = count_q != '0;
    assign m_data     = mem[rd_ptr_q];
    assign count      = count_q;
    assign overflow   = overflow_q;

    if (PIPE_LEVEL == 0) begin : g_direct
        assign wr_en   = s_data_vld;
        assign wr_data = s_data;
        assign s_read  = !full || pop;
    end else begin : g_pipe
        logic [PIPE_LEVEL-1:0] vld_q, cr_q;
        logic [DATA_WIDTH-1:0] dat_q [PIPE_LEVEL];
        logic                  credit;
        // Headroom of 2*PIPE_LEVEL covers writes granted during the credit round trip.
        assign credit = count_q < CNT_WIDTH'(DEPTH - 2*PIPE_LEVEL);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                cr_q  <= '1;
            end else begin
                vld_q[0] <= s_data_vld;
                cr_q[0]  <= credit;
                for (int i = 1; i < PIPE_LEVEL; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    cr_q[i]  <= cr_q[i-1];
                end
            end
        end
        always_ff @(posedge clk) begin
            if (s_data_vld) dat_q[0] <= s_data;
            for (int i = 1; i < PIPE_LEVEL; i++)
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
        end
        assign wr_en   = vld_q[PIPE_LEVEL-1];
        assign wr_data = dat_q[PIPE_LEVEL-1];
        assign s_read  = cr_q[PIPE_LEVEL-1];
    end
endmodule
